// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter in front of an 8N1 UART transmitter.
// Bit timing is derived from the system clock with an internal divide counter.
module uart_tx_scheduler #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned BAUD    = 9600,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                   clk50MHz,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   reqData,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   frameDone,
    output logic                   txd
);

    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_div;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [PW-1:0]   r_last;

    logic            w_bit_end;
    logic            w_found;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_win;
    logic [7:0]      w_win_data;

    assign w_bit_end = (r_div == CW'(DIV - 1));

    // Scan from lowest to highest priority so the requester nearest last+1 wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_win   = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            w_idx = PW'((int'(r_last) + k) % int'(NUM_REQ));
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_win_data = 8'h00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_win == PW'(i)) begin
                w_win_data = reqData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_last    <= PW'(NUM_REQ - 1);
            grant     <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            txd       <= 1'b1;
        end else begin
            grant     <= '0;
            frameDone <= 1'b0;
            if (r_state != S_IDLE) begin
                r_div <= w_bit_end ? '0 : r_div + CW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (w_found) begin
                        grant   <= NUM_REQ'(1) << w_win;
                        r_last  <= w_win;
                        r_shift <= w_win_data;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        r_div   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        txd     <= r_shift[0];
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == 3'd7) begin
                            txd     <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift <= {1'b0, r_shift[7:1]};
                            txd     <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        busy      <= 1'b0;
                        frameDone <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, random traffic, and a default-rate frame.
module tb_uart_tx_scheduler;

    localparam int N   = 3;
    localparam int DIV = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     grant;
    logic             busy, frame_done, txd;

    uart_tx_scheduler #(.CLK_HZ(80), .BAUD(10), .NUM_REQ(N)) dut (
        .clk50MHz (clk),
        .rst_n    (rst_n),
        .req      (req),
        .reqData  (req_data),
        .grant    (grant),
        .busy     (busy),
        .frameDone(frame_done),
        .txd      (txd)
    );

    logic         rst_nb;
    logic [1:0]   req_b;
    logic [15:0]  data_b;
    logic [1:0]   grant_b;
    logic         busy_b, fd_b, txd_b;
    bit           done_b = 1'b0;

    uart_tx_scheduler dut_b (
        .clk50MHz (clk),
        .rst_n    (rst_nb),
        .req      (req_b),
        .reqData  (data_b),
        .grant    (grant_b),
        .busy     (busy_b),
        .frameDone(fd_b),
        .txd      (txd_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: a frame is a byte plus its start cycle; outputs follow from the offset.
    int           cyc = 0;
    bit           m_active;
    int           m_t0;
    logic [7:0]   m_byte;
    int           m_last;
    logic [N-1:0] m_grant;
    bit           m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_last   = N - 1;
            m_grant  = '0;
            m_done   = 1'b0;
        end else begin
            cyc++;
            m_grant = '0;
            m_done  = 1'b0;
            if (m_active) begin
                if (cyc - m_t0 == 10 * DIV) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_active && req[(m_last + k) % N]) begin
                        m_last                 = (m_last + k) % N;
                        m_grant[m_last]        = 1'b1;
                        m_byte                 = req_data[8*m_last +: 8];
                        m_t0                   = cyc;
                        m_active               = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic exp_txd();
        int off, b;
        if (!m_active) return 1'b1;
        off = cyc - m_t0;
        b   = off / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    int   g_idx[$];
    int   g_cyc[$];
    int   fd_cyc[$];
    logic tx_log[$];
    int   mon_gi;
    logic [N+2:0] exp_vec, act_vec;

    // Per-cycle compare against the model, plus an event log for the directed checks.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_vec = {exp_txd(), m_active, m_done, m_grant};
            act_vec = {txd, busy, frame_done, grant};
            checks++;
            if (act_vec !== exp_vec) begin
                failures++;
                $display("FAIL cycle_cmp cyc=%0d {txd,busy,done,grant} actual=%b expected=%b",
                         cyc, act_vec, exp_vec);
            end
            if (|grant) begin
                mon_gi = -1;
                for (int i = N - 1; i >= 0; i--) if (grant[i]) mon_gi = i;
                g_idx.push_back(mon_gi);
                g_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            if (busy) tx_log.push_back(txd);
        end
    end

    task automatic wait_grant(input string name, output int idx, output int gc);
        int n0;
        n0  = g_idx.size();
        idx = -1;
        gc  = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (g_idx.size() > n0) begin
                idx = g_idx[n0];
                gc  = g_cyc[n0];
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL %s grant timeout actual=none expected=grant", name);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy) return;
            step();
        end
        checks++;
        failures++;
        $display("FAIL %s busy timeout actual=1 expected=0", name);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int exp1[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int exp2[4]  = '{0, 1, 0, 1};

    initial begin
        int idx, gc, fd0, n0, val, prev_gc, cnt1;
        rst_n    = 1'b1;
        req      = '0;
        req_data = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_done", frame_done, 0);
        step();
        step();

        // Single frame of 0xA5 from requester 0
        rst_n = 1'b1;
        req   = 3'b001;
        req_data[7:0] = 8'hA5;
        tx_log.delete();
        fd0 = fd_cyc.size();
        wait_grant("t1", idx, gc);
        check("t1_grant_idx", idx, 0);
        req = '0;
        wait_idle("t1");
        step();
        check("t1_done_count", fd_cyc.size() - fd0, 1);
        if (fd_cyc.size() > fd0) check("t1_frame_len", fd_cyc[fd0] - gc, 80);
        check("t1_busy_cycles", tx_log.size(), 80);
        if (tx_log.size() == 80) begin
            for (int b = 0; b < 10; b++) begin
                val = tx_log[b*8];
                for (int j = 1; j < 8; j++) if (tx_log[b*8+j] !== tx_log[b*8]) val = 2;
                check($sformatf("t1_bit%0d", b), val, exp1[b]);
            end
        end

        // Two requesters held: alternate grants spaced by one idle cycle
        pulse_reset();
        req      = 3'b011;
        req_data = {8'h00, 8'h22, 8'h11};
        prev_gc  = 0;
        for (int n = 0; n < 4; n++) begin
            wait_grant("t2", idx, gc);
            check($sformatf("t2_grant%0d", n), idx, exp2[n]);
            if (n > 0) check($sformatf("t2_gap%0d", n), gc - prev_gc, 81);
            prev_gc = gc;
        end
        req = '0;
        wait_idle("t2");

        // Pointer after granting 1 must favour 0 when both pend
        req = 3'b010;
        wait_grant("t3a", idx, gc);
        check("t3_first", idx, 1);
        req = 3'b011;
        wait_grant("t3b", idx, gc);
        check("t3_second", idx, 0);
        req = '0;
        wait_idle("t3");

        // One-cycle request while busy is never granted
        req = 3'b001;
        req_data[7:0] = 8'h3C;
        n0 = g_idx.size();
        wait_grant("t6", idx, gc);
        req = '0;
        repeat (20) step();
        req = 3'b010;
        step();
        req = '0;
        wait_idle("t6");
        repeat (20) step();
        cnt1 = 0;
        for (int i = n0; i < g_idx.size(); i++) if (g_idx[i] == 1) cnt1++;
        check("t6_no_grant1", cnt1, 0);
        check("t6_grants", g_idx.size() - n0, 1);
        check("t6_txd_idle", txd, 1);

        // Reset 35 cycles into a frame
        req = 3'b001;
        req_data[7:0] = 8'h5A;
        wait_grant("t4", idx, gc);
        for (int i = 0; i < 100 && cyc - gc < 35; i++) step();
        check("t4_offset", cyc - gc, 35);
        fd0 = fd_cyc.size();
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_txd", txd, 1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_grant", grant, 0);
        step();
        step();
        check("t4_no_done", fd_cyc.size() - fd0, 0);
        rst_n = 1'b1;
        wait_grant("t4b", idx, gc);
        check("t4_regrant", idx, 0);
        req = '0;
        wait_idle("t4");

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++) if ($urandom_range(0, 7) == 0) req[r] = ~req[r];
            if ($urandom_range(0, 3) == 0) req_data = 24'($urandom);
            step();
        end
        req = '0;
        wait_idle("rand");
        repeat (5) step();

        for (int i = 0; i < 70000 && !done_b; i++) step();
        check("b_finished", done_b, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Default-rate instance: byte 0x00 gives 9 low bits then one high stop bit
    initial begin
        int lo, hi;
        rst_nb = 1'b1;
        req_b  = '0;
        data_b = '0;
        #3 rst_nb = 1'b0;
        #1;
        check("b_rst_txd", txd_b, 1);
        step();
        step();
        rst_nb = 1'b1;
        req_b  = 2'b01;
        data_b = 16'h7700;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_b != 2'b00) break;
        end
        check("b_grant", grant_b, 1);
        req_b = '0;
        lo = 0;
        hi = 0;
        for (int i = 0; i < 60000; i++) begin
            if (fd_b) break;
            if (busy_b) begin
                if (txd_b) hi++;
                else lo++;
            end
            step();
        end
        check("b_low_cycles", lo, 46872);
        check("b_high_cycles", hi, 5208);
        check("b_done", fd_b, 1);
        check("b_busy_end", busy_b, 0);
        step();
        check("b_done_pulse", fd_b, 0);
        check("b_txd_idle", txd_b, 1);
        done_b = 1'b1;
    end

endmodule
